token_multiplier: RTL and testbench
===================================

# token_multiplier

Serial 1-bit token stream expander: every `1` token received on `a` is reproduced as `FACTOR` consecutive `1` tokens on `b`. It is the inverse end of the token-halving stream stage: a halver thins a stream and this block restores density. A saturating backlog counter holds tokens that are owed but not yet emitted, and a sticky flag reports any tokens that were lost.

## Interface
- `FACTOR`, default 2: output tokens per input token, legal range 1..15.
- `MAX_PENDING`, default 200: backlog capacity in tokens, must be ≥ `FACTOR`.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `a`  input  1  input token stream; one token per cycle when high.
- `b`  output  1  output token stream.
- `busy`  output  1  high while the backlog is non-zero.
- `overflow`  output  1  sticky; high once any token has been dropped.

## Operation
- The state is `pending`, an unsigned backlog of width `$clog2(MAX_PENDING+1)`, plus the `overflow` flag.
- Emission (base build): `b = a | (pending != 0)`, so a token emits in the same cycle it arrives.
- Next backlog before clamping: `nxt = pending + (a ? FACTOR : 0) - (b ? 1 : 0)`.
  - Compute it in a width at least 1 bit wider than `pending` plus the width of `FACTOR`.
- Clamping: if `nxt > MAX_PENDING`, then `pending <= MAX_PENDING` and `overflow <= 1`; otherwise `pending <= nxt`.
  - Excess tokens are silently dropped.
- `overflow` is cleared only by reset.
- `busy = (pending != 0)`, combinational from the register.
- `FACTOR = 1` degenerates to a pass-through: `b = a` and `pending` stays 0.
- Simultaneous arrival and emission in one cycle: both are applied in the same update, and the net backlog change is `FACTOR-1`.
- Sustained `a = 1`: the backlog grows by `FACTOR-1` per cycle and `b` stays high until `FACTOR×(ones)` tokens have been emitted.

## Timing
- Reset value of every output: `b = 0`, `busy = 0`, `overflow = 0`; `pending = 0`.
- Reset behaviour:
  - Assertion takes effect immediately, with no clock needed.
  - While `rst_n = 0`, `b` is forced to 0 regardless of `a`.
  - Reset mid-burst discards the whole backlog.
- First cycle after reset release: behaves as idle with an empty backlog.
- Latency, base build: 0 cycles from an `a` token to its first `b` token; `b` has a combinational path from `a`.
- Latency, registered build (see Configuration): 1 cycle.
- `overflow` rises on the clock edge that ends the cycle in which `nxt > MAX_PENDING`.
- Emission rate is at most 1 token per cycle.
- The output sequence always has no gaps: `b` stays high continuously while `busy` or `a` is high.

## Configuration
- Macro: `TOKEN_MULTIPLIER_REG_OUT_EN`.
- Defined (registered output):
  - `b` is a flop driven by the base-build expression, so every `b` token appears exactly one cycle later than in the base build.
  - `b` has no combinational path from `a`.
  - The `b` flop resets to 0 asynchronously.
  - `pending` and `overflow` behaviour is unchanged, cycle for cycle.
- Undefined (default): combinational `b`, exactly as described in Operation.

## Test plan
All scenarios use the default parameters and the base build unless stated.
- Isolated tokens: `a = 1000_1000_0000` → `b = 1100_1100_0000`; `busy` is high in cycles 1 and 5 only; `overflow = 0`.
- Back-to-back tokens: `a = 1100_0000` → `b = 1111_0000`; `pending` goes 1, 2, 1, 0.
- Overflow: hold `a = 1` for 201 cycles.
  - `pending` reaches 200 after cycle 200.
  - `overflow` rises at the end of cycle 201; `pending` is held at 200.
  - Release `a`: `b` stays high for exactly 200 more cycles, then `busy` drops.
- Reset mid-operation: `a = 1` for 10 cycles (`pending = 10`), then pulse `rst_n` low asynchronously mid-cycle.
  - `b`, `busy` and `overflow` go to 0 immediately.
  - After release with `a = 0`, `b` stays 0.
- `FACTOR = 3`: `a = 1010_0000` → `b = 1111_1100`; `pending` goes 2, 1, 3, 2, 1, 0.
- `TOKEN_MULTIPLIER_REG_OUT_EN` defined, with the first scenario's stimulus: `b = 0110_0110_0000`, and `pending` is identical to the base build.

Source files
------------

// File: rtl/token_multiplier.sv
// Serial token expander: each '1' on a becomes FACTOR consecutive '1' tokens on b,
// with a saturating backlog and sticky overflow. Define TOKEN_MULTIPLIER_REG_OUT_EN to register b.
module token_multiplier #(
    parameter int unsigned FACTOR      = 2,
    parameter int unsigned MAX_PENDING = 200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    output logic b,
    output logic busy,
    output logic overflow
);

    localparam int unsigned PW = $clog2(MAX_PENDING + 1);
    // Headroom for pending + FACTOR (FACTOR <= 15 fits in 4 bits) plus one spare bit.
    localparam int unsigned NW = PW + 5;

    logic [PW-1:0] pending;
    logic [NW-1:0] nxt;
    logic          emit;

    assign busy = (pending != '0);
    assign emit = rst_n & (a | busy);

    // emit implies a or a non-empty backlog, so the decrement can never underflow.
    always_comb begin
        nxt = NW'(pending);
        if (a)
            nxt = nxt + NW'(FACTOR);
        if (emit)
            nxt = nxt - NW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else if (nxt > NW'(MAX_PENDING)) begin
            pending  <= PW'(MAX_PENDING);
            overflow <= 1'b1;
        end else begin
            pending  <= nxt[PW-1:0];
        end
    end

`ifdef TOKEN_MULTIPLIER_REG_OUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            b <= 1'b0;
        else
            b <= emit;
    end
`else
    assign b = emit;
`endif

endmodule

// File: tb/tb_token_multiplier.sv
// Directed self-checking bench for token_multiplier (default and FACTOR=3 instances);
// expected b values shift by one cycle when TOKEN_MULTIPLIER_REG_OUT_EN is defined.
module tb_token_multiplier;

    logic clk = 1'b0;
    logic rst_n;
    logic a, a3;
    logic b, busy, overflow;
    logic b3, busy3, overflow3;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] pend_exp [16];

    token_multiplier dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .busy(busy), .overflow(overflow)
    );

    token_multiplier #(.FACTOR(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .a(a3), .b(b3), .busy(busy3), .overflow(overflow3)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One cycle per vector bit, cycle 0 in the MSB of the n-bit field.
    task automatic run_vec(input string tag, input bit sel3, input int n,
                           input logic [15:0] a_vec, input logic [15:0] b_vec,
                           input logic [15:0] busy_vec, input bit chk_p);
        logic eb;
        for (int i = 0; i < n; i++) begin
            if (sel3) a3 = a_vec[n-1-i];
            else      a  = a_vec[n-1-i];
`ifdef TOKEN_MULTIPLIER_REG_OUT_EN
            eb = (i == 0) ? 1'b0 : b_vec[n-i];
`else
            eb = b_vec[n-1-i];
`endif
            #3;
            check($sformatf("%s_b%0d", tag, i), sel3 ? b3 : b, eb);
            check($sformatf("%s_busy%0d", tag, i), sel3 ? busy3 : busy, busy_vec[n-1-i]);
            @(posedge clk);
            #1;
            if (chk_p)
                check($sformatf("%s_pend%0d", tag, i), sel3 ? dut3.pending : dut.pending, pend_exp[i]);
        end
        a  = 1'b0;
        a3 = 1'b0;
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0;
        a     = 1'b0;
        a3    = 1'b0;
        #2 a = 1'b1;
        #1;
        check("rst_b", b, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);
        check("rst_pend", dut.pending, 0);
        a = 1'b0;
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_vec("iso", 1'b0, 12, 16'b1000_1000_0000, 16'b1100_1100_0000, 16'b0100_0100_0000, 1'b0);
        check("iso_ovf", overflow, 0);

        pend_exp[0] = 8'd1; pend_exp[1] = 8'd2; pend_exp[2] = 8'd1; pend_exp[3] = 8'd0;
        pend_exp[4] = 8'd0; pend_exp[5] = 8'd0; pend_exp[6] = 8'd0; pend_exp[7] = 8'd0;
        run_vec("b2b", 1'b0, 8, 16'b1100_0000, 16'b1111_0000, 16'b0111_0000, 1'b1);

        // Saturation: 201 cycles of a=1, then drain.
        for (int i = 0; i < 201; i++) begin
            a = 1'b1;
            #3;
`ifdef TOKEN_MULTIPLIER_REG_OUT_EN
            if (i < 2) check($sformatf("ovf_b%0d", i), b, (i == 0) ? 0 : 1);
`else
            if (i < 2) check($sformatf("ovf_b%0d", i), b, 1);
`endif
            @(posedge clk);
            #1;
            if (i == 199) begin
                check("ovf_pend200", dut.pending, 200);
                check("ovf_flag_before", overflow, 0);
            end
        end
        check("ovf_flag", overflow, 1);
        check("ovf_pend_held", dut.pending, 200);
        a = 1'b0;
        cnt = 0;
        for (int i = 0; i < 400; i++) begin
            #3;
            if (!b) break;
            cnt++;
            @(posedge clk);
            #1;
        end
`ifdef TOKEN_MULTIPLIER_REG_OUT_EN
        check("drain_len", cnt, 201);
`else
        check("drain_len", cnt, 200);
`endif
        check("drain_busy", busy, 0);
        check("drain_ovf_sticky", overflow, 1);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 10; i++) begin
            a = 1'b1;
            @(posedge clk);
            #1;
        end
        check("mid_pend10", dut.pending, 10);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_b", b, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ovf", overflow, 0);
        check("mid_rst_pend", dut.pending, 0);
        a = 1'b0;
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_vec("post_rst", 1'b0, 3, 16'b000, 16'b000, 16'b000, 1'b0);

        pend_exp[0] = 8'd2; pend_exp[1] = 8'd1; pend_exp[2] = 8'd3; pend_exp[3] = 8'd2;
        pend_exp[4] = 8'd1; pend_exp[5] = 8'd0; pend_exp[6] = 8'd0; pend_exp[7] = 8'd0;
        run_vec("f3", 1'b1, 8, 16'b1010_0000, 16'b1111_1100, 16'b0111_1100, 1'b1);
        check("f3_ovf", overflow3, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
